// File: rtl/q2_filter_pkg.sv
// Shared constants, state type and helpers for the Q2 filter chain.
// Holds sample/accumulator widths, saturation limits and the warm-up state enum.
package q2_filter_pkg;
  localparam int DATA_W  = 4;
  localparam int FRAC_W  = 2;
  localparam int ACC_W   = 10;
  localparam int SAT_MAX = 7;
  localparam int SAT_MIN = -8;

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    FILL2,
    RUN
  } state_t;

  function automatic logic signed [ACC_W-1:0] sx(
    input logic [DATA_W-1:0] v
  );
    return ACC_W'($signed(v));
  endfunction
endpackage

// File: rtl/q2_round_sat.sv
// Round-half-up of a 2-fraction-bit accumulator to a 4-bit sample.
// Ports: acc (ACC_W signed) in; x (DATA_W) out; clip = result out of range.
// Q2_INV_SAT_EN: clamp to [SAT_MIN, SAT_MAX]; otherwise two's-complement wrap.
module q2_round_sat
  import q2_filter_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] x,
  output logic                     clip
);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] HI   = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO   = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] r;

  assign r = (acc + HALF) >>> FRAC_W;

  always_comb begin
    clip = (r > HI) || (r < LO);
`ifdef Q2_INV_SAT_EN
    if (r > HI)
      x = HI[DATA_W-1:0];
    else if (r < LO)
      x = LO[DATA_W-1:0];
    else
      x = r[DATA_W-1:0];
`else
    x = r[DATA_W-1:0];
`endif
  end
endmodule

// File: rtl/q2_inverse_filter.sv
// Inverse (equalizing) filter for the Q2 chain, valid/ready streaming, 1-cycle latency.
// Ports: clk, reset (async, active-low), clear, in_valid/in_ready/y_in,
// out_valid/out_ready/x_out, out_warm; sat_flag only with Q2_INV_SAT_EN.
module q2_inverse_filter
  import q2_filter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic              out_warm
`ifdef Q2_INV_SAT_EN
  ,
  output logic              sat_flag
`endif
);
  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] y1, y2;
  logic [DATA_W-1:0] x1, x2, x3;
  logic              accept;
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0] res;
  logic              clip;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Feedback uses the already rounded 4-bit outputs, keeping acc bounded.
  assign acc = (sx(y_in) <<< 2)
             - (sx(y1) <<< 1)
             - sx(y2)
             + ((sx(x1) - sx(x2) - sx(x3)) <<< 2);

  q2_round_sat u_rs (
    .acc  (acc),
    .x    (res),
    .clip (clip)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= FILL0;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL0;
    end else if (accept) begin
      unique case (state_q)
        FILL0:   state_d = FILL1;
        FILL1:   state_d = FILL2;
        FILL2:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1        <= '0;
      y2        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
      out_warm  <= 1'b0;
    end else if (clear) begin
      y1        <= '0;
      y2        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      out_valid <= 1'b0;
      out_warm  <= 1'b0;
    end else if (accept) begin
      y1        <= y_in;
      y2        <= y1;
      x1        <= res;
      x2        <= x1;
      x3        <= x2;
      x_out     <= res;
      out_valid <= 1'b1;
      out_warm  <= (state_q == FILL2) || (state_q == RUN);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef Q2_INV_SAT_EN
  // Sticky until reset; clear deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sat_flag <= 1'b0;
    else if (accept && clip)
      sat_flag <= 1'b1;
  end
`else
  logic unused_clip;
  assign unused_clip = clip;
`endif
endmodule

// File: tb/tb_q2_inverse_filter.sv
// Self-checking bench for q2_inverse_filter: directed literals plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_q2_inverse_filter;
  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] x_out;
  logic       out_warm;
`ifdef Q2_INV_SAT_EN
  logic       sat_flag;
  localparam int SAT4 = -8;
  localparam int C7_1 = 7;
`else
  localparam int SAT4 = 7;
  localparam int C7_1 = -5;
`endif

  int checks = 0;
  int errors = 0;

  q2_inverse_filter dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .out_warm  (out_warm)
`ifdef Q2_INV_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on signed sample values.
  int my1 = 0, my2 = 0, mx1 = 0, mx2 = 0, mx3 = 0, mcnt = 0, m_x = 0;
  bit m_valid = 0, m_warm = 0, m_sat = 0;

  function automatic int raw_r(input int y);
    int a;
    a = 4 * y - 2 * my1 - my2 + 4 * (mx1 - mx2 - mx3) + 2;
    return (a >= 0) ? a / 4 : -((-a + 3) / 4);
  endfunction

  function automatic int fin(input int r);
    int w;
`ifdef Q2_INV_SAT_EN
    if (r > 7) return 7;
    if (r < -8) return -8;
    return r;
`else
    w = ((r % 16) + 16) % 16;
    return (w >= 8) ? w - 16 : w;
`endif
  endfunction

  function automatic int sy();
    return int'($signed(y_in));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      my1 <= 0; my2 <= 0;
      mx1 <= 0; mx2 <= 0; mx3 <= 0;
      mcnt <= 0; m_x <= 0;
      m_valid <= 0; m_warm <= 0; m_sat <= 0;
    end else if (clear) begin
      my1 <= 0; my2 <= 0;
      mx1 <= 0; mx2 <= 0; mx3 <= 0;
      mcnt <= 0;
      m_valid <= 0; m_warm <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      my1 <= sy();
      my2 <= my1;
      mx1 <= fin(raw_r(sy()));
      mx2 <= mx1;
      mx3 <= mx2;
      m_x <= fin(raw_r(sy()));
      m_valid <= 1;
      m_warm <= (mcnt >= 2);
      mcnt <= (mcnt < 3) ? mcnt + 1 : 3;
      m_sat <= m_sat || (raw_r(sy()) > 7) || (raw_r(sy()) < -8);
    end else if (out_ready) begin
      m_valid <= 0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (reset === 1'b1) begin
      chk("in_ready", int'(in_ready), int'(!clear && (!m_valid || out_ready)));
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("x_out", int'($signed(x_out)), m_x);
        chk("out_warm", int'(out_warm), int'(m_warm));
      end
`ifdef Q2_INV_SAT_EN
      chk("sat_flag", int'(sat_flag), int'(m_sat));
`endif
    end
  end

  task automatic push(input logic [3:0] y, input int ex, input int ew,
                      input string nm);
    @(negedge clk);
    in_valid = 1'b1;
    y_in = y;
    @(posedge clk);
    #1;
    chk(nm, int'($signed(x_out)), ex);
    chk({nm, "_warm"}, int'(out_warm), ew);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    y_in = 4'd5;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

`ifdef Q2_INV_SAT_EN
  logic sat_save;
`endif

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_x", int'(x_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_warm", int'(out_warm), 0);
    chk("rst_ready", int'(in_ready), 1);
`ifdef Q2_INV_SAT_EN
    chk("rst_sat", int'(sat_flag), 0);
`endif

    push(4'd4, 4, 0, "imp0");
    push(4'd0, 2, 0, "imp1");
    push(4'd0, -3, 1, "imp2");
    push(4'd0, SAT4, 1, "imp3");
`ifdef Q2_INV_SAT_EN
    chk("imp_sat", int'(sat_flag), 1);
`endif

    do_clear();
    push(4'd7, 7, 0, "c7_0");
    push(4'd7, C7_1, 0, "c7_1");
`ifdef Q2_INV_SAT_EN
    chk("c7_sat", int'(sat_flag), 1);
`endif

    do_clear();
    push(4'd4, 4, 0, "bp0");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    y_in = 4'd0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_hold", int'($signed(x_out)), 4);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    push(4'd0, 2, 0, "bp1");
    push(4'd0, -3, 1, "bp2");
    push(4'd0, SAT4, 1, "bp3");

    do_clear();
    push(4'd4, 4, 0, "cl0");
    push(4'd0, 2, 0, "cl1");
`ifdef Q2_INV_SAT_EN
    sat_save = sat_flag;
`endif
    do_clear();
    push(4'd4, 4, 0, "clr0");
    push(4'd0, 2, 0, "clr1");
`ifdef Q2_INV_SAT_EN
    chk("clr_sat", int'(sat_flag), int'(sat_save));
`endif

    do_clear();
    push(4'd4, 4, 0, "rs0");
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", int'(out_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    push(4'd4, 4, 0, "rs_after");

    repeat (600) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      y_in      = 4'($urandom);
      clear     = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
